// File: rtl/pipelined_digit_subtractor.sv
// pipelined_digit_subtractor
// Computes diff = a - b - bin over WIDTH bits, one DIGIT_W-wide digit per
// cycle, least-significant digit first. The borrow between digits lives in a
// register. A start/busy/done handshake frames each operation. The zero and
// signed-overflow flags are produced together with the final result.
module pipelined_digit_subtractor #(
    parameter int WIDTH   = 16,
    parameter int DIGIT_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             zero,
    output logic             ovf
);

    localparam int NDIG  = WIDTH / DIGIT_W;
    localparam int CNT_W = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam logic [CNT_W-1:0] LAST_DIG = CNT_W'(NDIG - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_e;

    // Ripple of full-subtractor slices across one digit; returns {borrow_out, digit}.
    function automatic logic [DIGIT_W:0] sub_digit(
        input logic [DIGIT_W-1:0] x,
        input logic [DIGIT_W-1:0] y,
        input logic               br_in
    );
        logic               br;
        logic [DIGIT_W-1:0] d;
        br = br_in;
        d  = '0;
        for (int i = 0; i < DIGIT_W; i++) begin
            d[i] = x[i] ^ y[i] ^ br;
            br   = (~x[i] & y[i]) | (~(x[i] ^ y[i]) & br);
        end
        return {br, d};
    endfunction

    state_e             state_q;
    logic [WIDTH-1:0]   a_q;
    logic [WIDTH-1:0]   b_q;
    logic [WIDTH-1:0]   dsh_q;
    logic [WIDTH-1:0]   dsh_d;
    logic               brw_q;
    logic               brw_d;
    logic [CNT_W-1:0]   cnt_q;
    logic               busy_q;
    logic               done_q;
    logic [WIDTH-1:0]   diff_q;
    logic               bout_q;
    logic               zero_q;
    logic               ovf_q;

    logic [DIGIT_W-1:0] a_dig;
    logic [DIGIT_W-1:0] b_dig;
    logic [DIGIT_W-1:0] d_dig;
    logic               zero_d;
    logic               ovf_d;

    // Select the current digit, subtract it, and merge it into the shadow result.
    always_comb begin
        a_dig = '0;
        b_dig = '0;
        for (int k = 0; k < NDIG; k++) begin
            if (cnt_q == CNT_W'(k)) begin
                a_dig = a_q[k*DIGIT_W +: DIGIT_W];
                b_dig = b_q[k*DIGIT_W +: DIGIT_W];
            end
        end

        {brw_d, d_dig} = sub_digit(a_dig, b_dig, brw_q);

        dsh_d = dsh_q;
        for (int k = 0; k < NDIG; k++) begin
            if (cnt_q == CNT_W'(k)) begin
                dsh_d[k*DIGIT_W +: DIGIT_W] = d_dig;
            end
        end

        // Flags only matter on the last digit, when dsh_d holds the full result.
        zero_d = (dsh_d == '0);
        ovf_d  = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (dsh_d[WIDTH-1] != a_q[WIDTH-1]);
    end

    // Control FSM with registered handshake and result outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            dsh_q   <= '0;
            brw_q   <= 1'b0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            diff_q  <= '0;
            bout_q  <= 1'b0;
            zero_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        a_q     <= a;
                        b_q     <= b;
                        brw_q   <= bin;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= S_RUN;
                    end
                end

                S_RUN: begin
                    dsh_q <= dsh_d;
                    brw_q <= brw_d;
                    if (cnt_q == LAST_DIG) begin
                        // Last digit: publish the result and the flags together.
                        cnt_q   <= '0;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        diff_q  <= dsh_d;
                        bout_q  <= brw_d;
                        zero_q  <= zero_d;
                        ovf_q   <= ovf_d;
                        state_q <= S_DONE;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end

                S_DONE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        // Back-to-back accept straight out of the done cycle.
                        a_q     <= a;
                        b_q     <= b;
                        brw_q   <= bin;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= S_RUN;
                    end else begin
                        state_q <= S_IDLE;
                    end
                end

                default: begin
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    cnt_q   <= '0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign diff = diff_q;
    assign bout = bout_q;
    assign zero = zero_q;
    assign ovf  = ovf_q;

endmodule

// File: tb/tb_pipelined_digit_subtractor.sv
// Bench for pipelined_digit_subtractor: a 16-bit/4-bit-digit instance plus a
// 1-bit instance, checked against an arithmetic reference model.
module tb_pipelined_digit_subtractor;

    localparam int W  = 16;
    localparam int DW = 4;
    localparam int ND = W / DW;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         bin;
    logic         busy;
    logic         done;
    logic [W-1:0] diff;
    logic         bout;
    logic         zero;
    logic         ovf;

    logic s_start, s_a, s_b, s_bin;
    logic s_busy, s_done, s_diff, s_bout, s_zero, s_ovf;

    int total = 0;
    int bad   = 0;
    logic [W-1:0] last_diff;

    always #5 clk = ~clk;

    pipelined_digit_subtractor #(.WIDTH(W), .DIGIT_W(DW)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .bin(bin),
        .busy(busy), .done(done), .diff(diff), .bout(bout), .zero(zero), .ovf(ovf)
    );

    pipelined_digit_subtractor #(.WIDTH(1), .DIGIT_W(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(s_start), .a(s_a), .b(s_b), .bin(s_bin),
        .busy(s_busy), .done(s_done), .diff(s_diff), .bout(s_bout), .zero(s_zero), .ovf(s_ovf)
    );

    // Reference: plain integer subtraction; returns {ovf, zero, bout, diff}.
    function automatic logic [W+2:0] model(input logic [W-1:0] av, input logic [W-1:0] bv,
                                           input logic bi);
        int r;
        logic [W-1:0] d;
        logic bo, z, o;
        r  = int'(av) - int'(bv) - int'(bi);
        d  = W'(r);
        bo = (r < 0);
        z  = (d == '0);
        o  = (av[W-1] != bv[W-1]) && (d[W-1] != av[W-1]);
        return {o, z, bo, d};
    endfunction

    task automatic op16(input logic [W-1:0] av, input logic [W-1:0] bv, input logic bi);
        logic [W+2:0] e;
        int lat;
        e = model(av, bv, bi);
        @(negedge clk);
        start = 1'b1; a = av; b = bv; bin = bi;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
            start = 1'b0; a = W'($urandom); b = W'($urandom); bin = 1'($urandom);
            if (done !== 1'b1) begin
                total++;
                if (busy !== 1'b1) begin
                    bad++; $display("FAIL op_busy: busy=%b required 1 at cycle %0d", busy, lat);
                end
                total++;
                if (diff !== last_diff) begin
                    bad++; $display("FAIL op_hold: diff=%h required %h", diff, last_diff);
                end
            end
        end while (done !== 1'b1 && lat < 20);
        total++;
        if (lat != ND + 1) begin
            bad++; $display("FAIL op_latency: done after %0d cycles, required %0d", lat, ND + 1);
        end
        total++;
        if (busy !== 1'b0) begin
            bad++; $display("FAIL op_busy_done: busy=%b required 0", busy);
        end
        total++;
        if ({ovf, zero, bout, diff} !== e) begin
            bad++;
            $display("FAIL op_result a=%h b=%h bin=%b: ovf/zero/bout/diff=%b%b%b/%h required %b%b%b/%h",
                     av, bv, bi, ovf, zero, bout, diff, e[W+2], e[W+1], e[W], e[W-1:0]);
        end
        last_diff = e[W-1:0];
        @(negedge clk);
        total++;
        if (done !== 1'b0) begin
            bad++; $display("FAIL op_done_pulse: done=%b required 0", done);
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0; start = 1'b0; a = '0; b = '0; bin = 1'b0;
        s_start = 1'b0; s_a = 1'b0; s_b = 1'b0; s_bin = 1'b0;
        #1;
        total++;
        if ({busy, done, bout, zero, ovf} !== 5'b0 || diff !== '0) begin
            bad++; $display("FAIL reset_async: busy/done/bout/zero/ovf=%b%b%b%b%b diff=%h required 0",
                            busy, done, bout, zero, ovf, diff);
        end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        total++;
        if ({busy, done, bout, zero, ovf} !== 5'b0 || diff !== '0) begin
            bad++; $display("FAIL reset_idle: busy/done/bout/zero/ovf=%b%b%b%b%b diff=%h required 0",
                            busy, done, bout, zero, ovf, diff);
        end
        total++;
        if ({s_busy, s_done, s_diff, s_bout, s_zero, s_ovf} !== 6'b0) begin
            bad++; $display("FAIL reset_bit: outputs=%b required 000000",
                            {s_busy, s_done, s_diff, s_bout, s_zero, s_ovf});
        end
        last_diff = '0;
    endtask

    task automatic test_directed;
        op16(16'h1234, 16'h0235, 1'b0);
        op16(16'h0000, 16'h0001, 1'b0);
        op16(16'h8000, 16'h0001, 1'b0);
        op16(16'h0005, 16'h0005, 1'b0);
        op16(16'h0005, 16'h0005, 1'b1);
        op16(16'h7FFF, 16'hFFFF, 1'b0);
        op16(16'h8000, 16'h0000, 1'b1);
    endtask

    task automatic test_random;
        logic [W-1:0] av, bv;
        for (int n = 0; n < 30; n++) begin
            av = W'($urandom);
            bv = ($urandom_range(0, 4) == 0) ? av : W'($urandom);
            op16(av, bv, 1'($urandom));
        end
    endtask

    task automatic test_busy_ignore;
        logic [W+2:0] e;
        int lat;
        e = model(16'h00FF, 16'h0001, 1'b0);
        @(negedge clk);
        start = 1'b1; a = 16'h00FF; b = 16'h0001; bin = 1'b0;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
            if (lat <= 3) begin
                start = 1'b1; a = 16'hFFFF; b = W'($urandom); bin = 1'b1;
            end else begin
                start = 1'b0;
            end
        end while (done !== 1'b1 && lat < 20);
        total++;
        if (lat != ND + 1) begin
            bad++; $display("FAIL ignore_latency: done after %0d cycles, required %0d", lat, ND + 1);
        end
        total++;
        if ({ovf, zero, bout, diff} !== e) begin
            bad++; $display("FAIL ignore_result: diff=%h bout=%b required diff=%h bout=%b",
                            diff, bout, e[W-1:0], e[W]);
        end
        // Accept a new start during the done cycle.
        e = model(16'h4000, 16'h0123, 1'b1);
        start = 1'b1; a = 16'h4000; b = 16'h0123; bin = 1'b1;
        @(negedge clk);
        start = 1'b0;
        total++;
        if (busy !== 1'b1) begin
            bad++; $display("FAIL done_accept_busy: busy=%b required 1", busy);
        end
        lat = 1;
        while (done !== 1'b1 && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        total++;
        if (lat != ND + 1) begin
            bad++; $display("FAIL done_accept_latency: done after %0d cycles, required %0d", lat, ND + 1);
        end
        total++;
        if ({ovf, zero, bout, diff} !== e) begin
            bad++; $display("FAIL done_accept_result: diff=%h required %h", diff, e[W-1:0]);
        end
        last_diff = e[W-1:0];
        @(negedge clk);
    endtask

    task automatic test_back_to_back;
        logic [W-1:0] av, bv;
        logic bi;
        logic [W+2:0] e;
        int lat;
        av = W'($urandom); bv = W'($urandom); bi = 1'($urandom);
        @(negedge clk);
        start = 1'b1; a = av; b = bv; bin = bi;
        lat = 0;
        for (int n = 0; n < 3; n++) begin
            e = model(av, bv, bi);
            do begin
                @(negedge clk);
                lat++;
                if (done !== 1'b1) begin
                    a = W'($urandom); b = W'($urandom); bin = 1'($urandom);
                end
            end while (done !== 1'b1 && lat < 20);
            total++;
            if (lat != ND + 1) begin
                bad++; $display("FAIL b2b_period op %0d: %0d cycles, required %0d", n, lat, ND + 1);
            end
            total++;
            if ({ovf, zero, bout, diff} !== e) begin
                bad++; $display("FAIL b2b_result op %0d: diff=%h bout=%b required diff=%h bout=%b",
                                n, diff, bout, e[W-1:0], e[W]);
            end
            last_diff = e[W-1:0];
            if (n < 2) begin
                av = W'($urandom); bv = W'($urandom); bi = 1'($urandom);
                a = av; b = bv; bin = bi;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            lat = 1;
            total++;
            if (busy !== (n < 2 ? 1'b1 : 1'b0)) begin
                bad++; $display("FAIL b2b_busy op %0d: busy=%b required %b", n, busy, (n < 2));
            end
        end
    endtask

    task automatic test_reset_midrun;
        op16(16'h8000, 16'h0001, 1'b0);
        @(negedge clk);
        start = 1'b1; a = 16'h1357; b = 16'h0246; bin = 1'b0;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        total++;
        if ({busy, done, bout, zero, ovf} !== 5'b0 || diff !== '0) begin
            bad++; $display("FAIL midrun_reset: busy/done/bout/zero/ovf=%b%b%b%b%b diff=%h required 0",
                            busy, done, bout, zero, ovf, diff);
        end
        rst_n = 1'b1;
        for (int n = 0; n < 8; n++) begin
            @(negedge clk);
            total++;
            if (done !== 1'b0 || busy !== 1'b0) begin
                bad++; $display("FAIL midrun_quiet: done=%b busy=%b required 0 0", done, busy);
            end
        end
        last_diff = '0;
        op16(16'h1357, 16'h0246, 1'b0);
    endtask

    task automatic test_bit_sweep;
        int r;
        logic ed, eb;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            s_start = 1'b1; s_a = k[2]; s_b = k[1]; s_bin = k[0];
            r  = int'(s_a) - int'(s_b) - int'(s_bin);
            ed = r[0];
            eb = (r < 0);
            @(negedge clk);
            s_start = 1'b0;
            total++;
            if (s_busy !== 1'b1 || s_done !== 1'b0) begin
                bad++; $display("FAIL bit_run %0d: busy=%b done=%b required 1 0", k, s_busy, s_done);
            end
            @(negedge clk);
            total++;
            if (s_done !== 1'b1 || s_busy !== 1'b0) begin
                bad++; $display("FAIL bit_done %0d: done=%b busy=%b required 1 0", k, s_done, s_busy);
            end
            total++;
            if ({s_diff, s_bout, s_zero} !== {ed, eb, ~ed}) begin
                bad++; $display("FAIL bit_result %0d: diff/bout/zero=%b%b%b required %b%b%b",
                                k, s_diff, s_bout, s_zero, ed, eb, ~ed);
            end
        end
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_busy_ignore();
        test_back_to_back();
        test_reset_midrun();
        test_bit_sweep();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

endmodule
